// File: rtl/ibex_timer_resp.sv
// ibex_timer_resp: memory-mapped machine timer (mtime/mtimecmp) with a prescaler and a timer interrupt
module ibex_timer_resp #(
    parameter int unsigned PrescaleWidth = 8,
    parameter logic [63:0] MtimeResetVal = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        timer_irq_o
);
    localparam logic [31:0] CtrlMask = {{(24 - PrescaleWidth){1'b0}}, {PrescaleWidth{1'b1}}, 8'h01};
    logic [63:0] mtime_q, mtimecmp_q;
    logic [31:0] ctrl_q, snap_q, wmask, rdata_d;
    logic [PrescaleWidth-1:0] cnt_q;
    logic [4:0] off;
    logic [2:0] sel;
    logic bad, wr, rd, tick, en;
    logic unused_addr;
    assign unused_addr = ^data_addr_i[31:5];
    assign data_gnt_o = data_req_i;
    assign off = data_addr_i[4:0];
    assign sel = off[4:2];
    assign bad = (off[1:0] != 2'b00) || (off[4:3] == 2'b11);
    assign wr = data_req_i && data_we_i && !bad && (data_be_i != 4'b0000);
    assign rd = data_req_i && !data_we_i && !bad;
    assign wmask = {{8{data_be_i[3]}}, {8{data_be_i[2]}}, {8{data_be_i[1]}}, {8{data_be_i[0]}}};
    assign en = ctrl_q[0];
    assign tick = en && (cnt_q == ctrl_q[8 +: PrescaleWidth]);
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [31:0] m);
        return (old & ~m) | (wd & m);
    endfunction
    // mtime: a word write replaces that word and suppresses the tick, otherwise count on tick
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) mtime_q <= MtimeResetVal;
        else if (wr && sel == 3'd0) mtime_q[31:0] <= merge(mtime_q[31:0], data_wdata_i, wmask);
        else if (wr && sel == 3'd1) mtime_q[63:32] <= merge(mtime_q[63:32], data_wdata_i, wmask);
        else if (tick) mtime_q <= mtime_q + 64'd1;
    end
    // mtimecmp: byte-granular software writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) mtimecmp_q <= '1;
        else if (wr && sel == 3'd2) mtimecmp_q[31:0] <= merge(mtimecmp_q[31:0], data_wdata_i, wmask);
        else if (wr && sel == 3'd3) mtimecmp_q[63:32] <= merge(mtimecmp_q[63:32], data_wdata_i, wmask);
    end
    // CTRL register keeps only the EN and PRESCALE bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ctrl_q <= '0;
        else if (wr && sel == 3'd4) ctrl_q <= merge(ctrl_q, data_wdata_i, wmask) & CtrlMask;
    end
    // prescale counter restarts on a CTRL write or after each tick
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else if ((wr && sel == 3'd4) || tick) cnt_q <= '0;
        else if (en) cnt_q <= cnt_q + 1'b1;
    end
    // a low-word read captures the matching high word for a consistent 64-bit read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) snap_q <= '0;
        else if (rd && sel == 3'd0) snap_q <= mtime_q[63:32];
    end
    // read mux over pre-update register state; writes and errors return zero
    always_comb begin
        rdata_d = !rd ? 32'h0 :
                  sel == 3'd0 ? mtime_q[31:0] :
                  sel == 3'd1 ? mtime_q[63:32] :
                  sel == 3'd2 ? mtimecmp_q[31:0] :
                  sel == 3'd3 ? mtimecmp_q[63:32] :
                  sel == 3'd4 ? ctrl_q :
                  sel == 3'd5 ? snap_q : 32'h0;
    end
    // one-cycle response pipeline and registered interrupt level
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b0;
            timer_irq_o   <= 1'b0;
        end else begin
            data_rvalid_o <= data_req_i;
            data_rdata_o  <= rdata_d;
            data_err_o    <= data_req_i && bad;
            timer_irq_o   <= mtime_q >= mtimecmp_q;
        end
    end
endmodule

// File: tb/tb_ibex_timer_resp.sv
// tb_ibex_timer_resp: directed and randomized checks of ibex_timer_resp against a behavioural model
module tb_ibex_timer_resp;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        timer_irq_o;
    int n_vec = 0;
    int n_err = 0;
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_ctrl, m_snap;
    int m_cnt;
    ibex_timer_resp dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .data_err_o(data_err_o), .timer_irq_o(timer_irq_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask
    function automatic logic [31:0] bytes_in(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction
    function automatic logic [31:0] reg_val(input logic [4:0] off);
        case (off)
            5'h00: return m_time[31:0];
            5'h04: return m_time[63:32];
            5'h08: return m_cmp[31:0];
            5'h0C: return m_cmp[63:32];
            5'h10: return m_ctrl;
            5'h14: return m_snap;
            default: return 32'h0;
        endcase
    endfunction
    task automatic model_reset();
        m_time = 64'h0;
        m_cmp = '1;
        m_ctrl = 32'h0;
        m_snap = 32'h0;
        m_cnt = 0;
    endtask
    // one bus cycle: drive, predict from the model, advance the model, then check the response
    task automatic cyc(input logic r, input logic w, input logic [4:0] off, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] up = $urandom();
        logic bad = (off[1:0] != 2'b00) || (off >= 5'h18);
        logic [31:0] e_rd;
        logic e_irq;
        logic do_wr = r && w && !bad && (be != 4'h0);
        logic tick;
        int ps;
        data_req_i = r;
        data_we_i = w;
        data_addr_i = {up[31:5], off};
        data_be_i = be;
        data_wdata_i = wd;
        e_rd = (r && !w && !bad) ? reg_val(off) : 32'h0;
        e_irq = m_time >= m_cmp;
        ps = int'(m_ctrl[15:8]);
        tick = m_ctrl[0] && (m_cnt == ps);
        if (r && !w && !bad && off == 5'h00) m_snap = m_time[63:32];
        if (do_wr && off == 5'h10) m_cnt = 0;
        else if (m_ctrl[0]) m_cnt = tick ? 0 : (m_cnt + 1) % 256;
        if (do_wr && off == 5'h00) m_time[31:0] = bytes_in(m_time[31:0], wd, be);
        else if (do_wr && off == 5'h04) m_time[63:32] = bytes_in(m_time[63:32], wd, be);
        else if (tick) m_time = m_time + 64'd1;
        if (do_wr && off == 5'h08) m_cmp[31:0] = bytes_in(m_cmp[31:0], wd, be);
        if (do_wr && off == 5'h0C) m_cmp[63:32] = bytes_in(m_cmp[63:32], wd, be);
        if (do_wr && off == 5'h10) m_ctrl = bytes_in(m_ctrl, wd, be) & 32'h0000_FF01;
        #1 check("gnt", 32'(data_gnt_o), 32'(r));
        @(posedge clk_i);
        @(negedge clk_i);
        check("rvalid", 32'(data_rvalid_o), 32'(r));
        check("rdata", data_rdata_o, e_rd);
        check("err", 32'(data_err_o), 32'(r && bad));
        check("irq", 32'(timer_irq_o), 32'(e_irq));
    endtask
    task automatic wr32(input logic [4:0] off, input logic [31:0] wd);
        cyc(1'b1, 1'b1, off, 4'hF, wd);
    endtask
    task automatic rd32(input logic [4:0] off);
        cyc(1'b1, 1'b0, off, 4'($urandom()), 32'($urandom()));
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'h0, 4'h0, 32'h0);
    endtask
    initial begin
        model_reset();
        repeat (3) @(negedge clk_i);
        check("rst_rvalid", 32'(data_rvalid_o), 32'h0);
        check("rst_rdata", data_rdata_o, 32'h0);
        check("rst_irq", 32'(timer_irq_o), 32'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) rd32(5'(4 * i));
        wr32(5'h10, 32'h0000_0301);
        idle(40);
        rd32(5'h00);
        wr32(5'h10, 32'h0000_0001);
        wr32(5'h00, 32'hFFFF_FFFF);
        wr32(5'h04, 32'h0);
        rd32(5'h00);
        rd32(5'h14);
        rd32(5'h00);
        rd32(5'h14);
        wr32(5'h0C, 32'h0);
        wr32(5'h08, 32'd20);
        wr32(5'h04, 32'h0);
        wr32(5'h00, 32'h0);
        idle(25);
        wr32(5'h0C, 32'h1);
        idle(2);
        wr32(5'h00, 32'h0000_AB00);
        cyc(1'b1, 1'b1, 5'h00, 4'b0001, 32'h0000_0012);
        rd32(5'h00);
        rd32(5'h04);
        cyc(1'b1, 1'b1, 5'h08, 4'b0000, 32'hDEAD_BEEF);
        cyc(1'b1, 1'b1, 5'h14, 4'hF, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) rd32(5'(4 * i));
        rd32(5'h03);
        cyc(1'b1, 1'b1, 5'h01, 4'hF, 32'h5555_5555);
        rd32(5'h08);
        data_req_i = 1'b1;
        data_we_i = 1'b0;
        data_addr_i = 32'h0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("pre_rst_rvalid", 32'(data_rvalid_o), 32'h1);
        rst_i = 1'b1;
        #1 check("mid_rst_rvalid", 32'(data_rvalid_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        idle(1);
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] off;
            logic [31:0] wd;
            int k = $urandom_range(0, 9);
            int s = $urandom_range(0, 3);
            off = (k < 8) ? 5'(4 * k) : 5'($urandom_range(0, 31));
            wd = (s == 0) ? 32'($urandom_range(0, 64)) : (s == 1) ? 32'h0 : (s == 2) ? 32'hFFFF_FFFF : 32'($urandom());
            if (off == 5'h10 && $urandom_range(0, 3) != 0) wd = {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom())};
            cyc(1'($urandom_range(0, 9) < 7), 1'($urandom()), off, 4'($urandom()), wd);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
